// File: rtl/traffic_phase_controller.sv
// Two-direction intersection phase scheduler: green/yellow/all-red sequencing with
// pedestrian walk service and an emergency all-red override.
module traffic_phase_controller #(
   parameter int unsigned CLK_DIV      = 100,
   parameter int unsigned GREEN_TICKS  = 20,
   parameter int unsigned YELLOW_TICKS = 4,
   parameter int unsigned ALLRED_TICKS = 2,
   parameter int unsigned PED_TICKS    = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ped_req,
   input  logic        emerg,
   output logic [1:0]  ns_light,
   output logic [1:0]  ew_light,
   output logic        walk,
   output logic        ped_ack,
   output logic [2:0]  phase,
   output logic [31:0] counter
);

   typedef enum logic [2:0] {
      StNsG     = 3'd0,
      StNsY     = 3'd1,
      StRedNs   = 3'd2,
      StEwG     = 3'd3,
      StEwY     = 3'd4,
      StRedEw   = 3'd5,
      StPedWalk = 3'd6,
      StEmerg   = 3'd7
   } state_e;

   localparam logic [31:0] DivMax     = 32'(CLK_DIV - 1);
   localparam logic [31:0] GreenLoad  = 32'(GREEN_TICKS - 1);
   localparam logic [31:0] YellowLoad = 32'(YELLOW_TICKS - 1);
   localparam logic [31:0] AllredLoad = 32'(ALLRED_TICKS - 1);
   localparam logic [31:0] PedLoad    = 32'(PED_TICKS - 1);

   state_e      state_q, state_d;
   logic [31:0] presc_q, presc_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] count_q, count_d;
   logic        pend_q, pend_d;
   logic        dir_ew_q, dir_ew_d;
   logic        recover_q, recover_d;
   logic        ack_q, ack_d;
   logic        tick, expire, entry;
   logic [31:0] load;

   always_comb begin
      tick      = (presc_q == DivMax);
      expire    = tick && (timer_q == 32'd0);
      state_d   = state_q;
      dir_ew_d  = dir_ew_q;
      if (emerg) begin
         state_d = StEmerg;
      end else begin
         case (state_q)
            StEmerg: state_d = StRedEw;
            StNsG:   if (expire) state_d = StNsY;
            StNsY:   if (expire) state_d = StRedNs;
            StEwG:   if (expire) state_d = StEwY;
            StEwY:   if (expire) state_d = StRedEw;
            StRedNs: begin
               if (expire) begin
                  if (pend_q) begin
                     state_d  = StPedWalk;
                     dir_ew_d = 1'b1;
                  end else begin
                     state_d = StEwG;
                  end
               end
            end
            StRedEw: begin
               // The clearance following an emergency always resumes with NS green.
               if (expire) begin
                  if (pend_q && !recover_q) begin
                     state_d  = StPedWalk;
                     dir_ew_d = 1'b0;
                  end else begin
                     state_d = StNsG;
                  end
               end
            end
            StPedWalk: if (expire) state_d = dir_ew_q ? StEwG : StNsG;
            default:   state_d = StRedEw;
         endcase
      end

      entry = (state_d != state_q);

      case (state_d)
         StNsG, StEwG:     load = GreenLoad;
         StNsY, StEwY:     load = YellowLoad;
         StRedNs, StRedEw: load = AllredLoad;
         StPedWalk:        load = PedLoad;
         default:          load = 32'd0;
      endcase

      recover_d = entry ? (state_q == StEmerg) : recover_q;
      presc_d   = (entry || tick) ? 32'd0 : presc_q + 32'd1;
      if (entry)                          timer_d = load;
      else if (tick && timer_q != 32'd0)  timer_d = timer_q - 32'd1;
      else                                timer_d = timer_q;
      if (entry)     count_d = 32'd0;
      else if (tick) count_d = count_q + 32'd1;
      else           count_d = count_q;

      ack_d  = ped_req && !pend_q && (state_q != StPedWalk);
      pend_d = pend_q | ack_d;
      if (entry && state_d == StPedWalk) pend_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StRedEw;
         presc_q   <= 32'd0;
         timer_q   <= AllredLoad;
         count_q   <= 32'd0;
         pend_q    <= 1'b0;
         dir_ew_q  <= 1'b0;
         recover_q <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         timer_q   <= timer_d;
         count_q   <= count_d;
         pend_q    <= pend_d;
         dir_ew_q  <= dir_ew_d;
         recover_q <= recover_d;
         ack_q     <= ack_d;
      end
   end

   always_comb begin
      ns_light = 2'b00;
      ew_light = 2'b00;
      case (state_q)
         StNsG:   ns_light = 2'b10;
         StNsY:   ns_light = 2'b01;
         StEwG:   ew_light = 2'b10;
         StEwY:   ew_light = 2'b01;
         default: ;
      endcase
      walk    = (state_q == StPedWalk);
      phase   = state_q;
      ped_ack = ack_q;
      counter = count_q;
   end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: a vector table for the free-running
// cycle plus hand-written pedestrian, emergency and reset sequences.
module tb_traffic_phase_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ped_req = 1'b0;
   logic        emerg = 1'b0;
   logic [1:0]  ns_light, ew_light;
   logic        walk, ped_ack;
   logic [2:0]  phase;
   logic [31:0] counter;

   int n_checks = 0;
   int n_fail = 0;

   traffic_phase_controller #(
      .CLK_DIV(2), .GREEN_TICKS(3), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .PED_TICKS(2)
   ) dut (
      .clk(clk), .reset(reset), .ped_req(ped_req), .emerg(emerg),
      .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .ped_ack(ped_ack),
      .phase(phase), .counter(counter)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ped_req;
      logic        emerg;
      logic [2:0]  phase;
      logic [1:0]  ns;
      logic [1:0]  ew;
      logic        walk;
      logic        ack;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[27];

   function automatic logic [1:0] exp_ns(input int p);
      return (p == 0) ? 2'b10 : (p == 1) ? 2'b01 : 2'b00;
   endfunction

   function automatic logic [1:0] exp_ew(input int p);
      return (p == 3) ? 2'b10 : (p == 4) ? 2'b01 : 2'b00;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset released between edges; sample index 0 is taken before the first edge after release.
   task automatic do_reset();
      reset = 1'b1;
      ped_req = 1'b0;
      emerg = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int plist[8];
      int clist[8];
      int idx;
      int acks;
      int bad_acks;

      plist = '{5, 0, 1, 2, 3, 4, 5, 0};
      clist = '{2, 6, 4, 2, 6, 4, 2, 1};
      idx = 0;
      for (int p = 0; p < 8; p++) begin
         for (int j = 0; j < clist[p]; j++) begin
            vecs[idx].ped_req = 1'b0;
            vecs[idx].emerg   = 1'b0;
            vecs[idx].phase   = 3'(plist[p]);
            vecs[idx].ns      = exp_ns(plist[p]);
            vecs[idx].ew      = exp_ew(plist[p]);
            vecs[idx].walk    = 1'b0;
            vecs[idx].ack     = 1'b0;
            vecs[idx].cnt     = 32'(j / 2);
            idx++;
         end
      end

      // Free-running cycle, no requests
      do_reset();
      for (int i = 0; i < 27; i++) begin
         ped_req = vecs[i].ped_req;
         emerg   = vecs[i].emerg;
         check($sformatf("v%0d phase", i), 32'(phase), 32'(vecs[i].phase));
         check($sformatf("v%0d ns", i), 32'(ns_light), 32'(vecs[i].ns));
         check($sformatf("v%0d ew", i), 32'(ew_light), 32'(vecs[i].ew));
         check($sformatf("v%0d walk", i), 32'(walk), 32'(vecs[i].walk));
         check($sformatf("v%0d ack", i), 32'(ped_ack), 32'(vecs[i].ack));
         check($sformatf("v%0d counter", i), counter, vecs[i].cnt);
         step();
      end

      // Single pedestrian pulse during NS green
      do_reset();
      acks = 0;
      for (int k = 0; k <= 24; k++) begin
         ped_req = (k == 3);
         if (ped_ack) acks++;
         if (k == 4)  check("ped ack latency", 32'(ped_ack), 32'd1);
         if (k == 13) check("ped red_ns", 32'(phase), 32'd2);
         if (k == 14) check("ped walk entry", 32'(phase), 32'd6);
         if (k == 14) check("ped walk lamp", 32'(walk), 32'd1);
         if (k == 17) check("ped walk end", 32'(phase), 32'd6);
         if (k == 18) check("ped then ew_g", 32'(phase), 32'd3);
         if (k == 18) check("ped ew lamp", 32'(ew_light), 32'd2);
         if (k == 18) check("ped walk off", 32'(walk), 32'd0);
         step();
      end
      check("ped single ack count", 32'(acks), 32'd1);

      // Request held high: one ack per service, none during walk
      do_reset();
      acks = 0;
      bad_acks = 0;
      for (int k = 0; k <= 40; k++) begin
         ped_req = (k < 40);
         if (ped_ack) acks++;
         if (ped_ack && phase == 3'd6) bad_acks++;
         if (k == 1)  check("held ack 1", 32'(ped_ack), 32'd1);
         if (k == 2)  check("held walk from red_ew", 32'(phase), 32'd6);
         if (k == 6)  check("held then ns_g", 32'(phase), 32'd0);
         if (k == 7)  check("held ack 2", 32'(ped_ack), 32'd1);
         if (k == 18) check("held walk from red_ns", 32'(phase), 32'd6);
         if (k == 22) check("held then ew_g", 32'(phase), 32'd3);
         if (k == 23) check("held ack 3", 32'(ped_ack), 32'd1);
         if (k == 34) check("held walk 3", 32'(phase), 32'd6);
         if (k == 39) check("held ack 4", 32'(ped_ack), 32'd1);
         step();
      end
      check("held ack count", 32'(acks), 32'd4);
      check("held ack in walk", 32'(bad_acks), 32'd0);

      // Emergency during EW green
      do_reset();
      for (int k = 0; k <= 25; k++) begin
         emerg = (k >= 16 && k < 21);
         if (k == 17) check("emerg entry", 32'(phase), 32'd7);
         if (k == 17) check("emerg ns", 32'(ns_light), 32'd0);
         if (k == 17) check("emerg ew", 32'(ew_light), 32'd0);
         if (k == 20) check("emerg hold", 32'(phase), 32'd7);
         if (k == 21) check("emerg counter", counter, 32'd2);
         if (k == 22) check("emerg exit red_ew", 32'(phase), 32'd5);
         if (k == 23) check("emerg red_ew hold", 32'(phase), 32'd5);
         if (k == 24) check("emerg then ns_g", 32'(phase), 32'd0);
         step();
      end

      // Emergency on the yellow-expiry edge with a pending request
      do_reset();
      for (int k = 0; k <= 32; k++) begin
         ped_req = (k == 3);
         emerg   = (k == 11 || k == 12);
         if (k == 4)  check("e+p ack", 32'(ped_ack), 32'd1);
         if (k == 12) check("e+p emerg wins", 32'(phase), 32'd7);
         if (k == 14) check("e+p red_ew", 32'(phase), 32'd5);
         if (k == 16) check("e+p ns_g", 32'(phase), 32'd0);
         if (k == 26) check("e+p red_ns", 32'(phase), 32'd2);
         if (k == 28) check("e+p walk", 32'(phase), 32'd6);
         if (k == 28) check("e+p walk lamp", 32'(walk), 32'd1);
         if (k == 32) check("e+p ew_g", 32'(phase), 32'd3);
         step();
      end

      // Asynchronous reset in the middle of a walk
      do_reset();
      for (int k = 0; k <= 16; k++) begin
         ped_req = (k == 3);
         if (k == 16) check("pre-reset counter", counter, 32'd1);
         if (k < 16) step();
      end
      #2;
      check("pre-reset walk", 32'(walk), 32'd1);
      reset = 1'b1;
      ped_req = 1'b0;
      #1;
      check("async rst phase", 32'(phase), 32'd5);
      check("async rst walk", 32'(walk), 32'd0);
      check("async rst counter", counter, 32'd0);
      check("async rst lamps", 32'({ns_light, ew_light}), 32'd0);
      check("async rst ack", 32'(ped_ack), 32'd0);
      do_reset();
      for (int k = 0; k <= 14; k++) begin
         if (k == 1)  check("restart red_ew", 32'(phase), 32'd5);
         if (k == 2)  check("restart ns_g no walk", 32'(phase), 32'd0);
         if (k == 12) check("restart red_ns", 32'(phase), 32'd2);
         if (k == 14) check("restart ew_g", 32'(phase), 32'd3);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
